// File: rtl/life_grid_engine.sv
// 12x12 Game-of-Life grid owner and pixiv colour writer (rule B3/S23).
// Generations are scanned one cell per cycle into a shadow buffer and committed in one cycle.
module life_grid_engine #(
  parameter int ROWS     = 12,
  parameter int COLS     = 12,
  parameter int TICK_DIV = 50_000_000,
  parameter int WRAP     = 1
) (
  input  logic        clk_in,
  input  logic        reset_btn,
  input  logic        run,
  input  logic        step,
  input  logic        edit_we,
  input  logic [3:0]  edit_row,
  input  logic [3:0]  edit_col,
  input  logic        edit_val,
  input  logic        show_cursor,
  output logic [1:0]  pixiv [ROWS][COLS],
  output logic        busy,
  output logic [15:0] generation
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_R    = 4'(ROWS - 1);
  localparam logic [3:0]    LAST_C    = 4'(COLS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_cur;
  logic [N-1:0]    r_nxt;
  logic [3:0]      r_row;
  logic [3:0]      r_col;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_tick;
  logic            r_pending;
  logic            r_busy;
  logic [15:0]     r_gen;
  logic [2*N-1:0]  r_pix;

  logic            w_edit_ok;
  logic [IW-1:0]   w_edit_idx;
  logic            w_tick_hit;
  logic            w_trigger;
  logic            w_cursor_ok;
  logic [3:0]      w_nr [3];
  logic [3:0]      w_nc [3];
  logic [2:0]      w_nr_ok;
  logic [2:0]      w_nc_ok;
  logic [8:0]      w_hit;
  logic [3:0]      w_ncount;
  logic            w_new_cell;
  logic [2*N-1:0]  w_pix;

  assign w_edit_ok   = edit_we && ({1'b0, edit_row} < 5'(ROWS)) && ({1'b0, edit_col} < 5'(COLS));
  assign w_edit_idx  = IW'(edit_row) * IW'(COLS) + IW'(edit_col);
  assign w_tick_hit  = run && (r_tick == TICK_LAST);
  assign w_trigger   = step || w_tick_hit || r_pending;
  assign w_cursor_ok = show_cursor && ({1'b0, edit_row} < 5'(ROWS)) && ({1'b0, edit_col} < 5'(COLS));

  // Neighbour coordinates; with WRAP=0 an off-grid neighbour is flagged invalid and counts as dead.
  assign w_nr[0]    = (r_row == 4'd0) ? LAST_R : r_row - 4'd1;
  assign w_nr[1]    = r_row;
  assign w_nr[2]    = (r_row == LAST_R) ? 4'd0 : r_row + 4'd1;
  assign w_nc[0]    = (r_col == 4'd0) ? LAST_C : r_col - 4'd1;
  assign w_nc[1]    = r_col;
  assign w_nc[2]    = (r_col == LAST_C) ? 4'd0 : r_col + 4'd1;
  assign w_nr_ok[0] = (r_row != 4'd0) || (WRAP != 0);
  assign w_nr_ok[1] = 1'b1;
  assign w_nr_ok[2] = (r_row != LAST_R) || (WRAP != 0);
  assign w_nc_ok[0] = (r_col != 4'd0) || (WRAP != 0);
  assign w_nc_ok[1] = 1'b1;
  assign w_nc_ok[2] = (r_col != LAST_C) || (WRAP != 0);

  for (genvar gi = 0; gi < 3; gi++) begin : g_nrow
    for (genvar gj = 0; gj < 3; gj++) begin : g_ncol
      if (gi == 1 && gj == 1) begin : g_self
        assign w_hit[gi*3+gj] = 1'b0;
      end else begin : g_nb
        assign w_hit[gi*3+gj] = w_nr_ok[gi] && w_nc_ok[gj] &&
                                r_cur[IW'(w_nr[gi]) * IW'(COLS) + IW'(w_nc[gj])];
      end
    end
  end

  assign w_ncount   = 4'($countones(w_hit));
  assign w_new_cell = (w_ncount == 4'd3) || (r_cur[r_idx] && (w_ncount == 4'd2));

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_nxt     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_tick    <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_gen     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_tick <= w_tick_hit ? '0 : r_tick + 1'b1;
          if (w_edit_ok) r_cur[w_edit_idx] <= edit_val;
          // An edit coinciding with a trigger wins this cycle; the trigger fires next cycle.
          if (w_trigger) begin
            if (w_edit_ok) begin
              r_pending <= 1'b1;
            end else begin
              r_pending <= 1'b0;
              r_state   <= S_SCAN;
              r_busy    <= 1'b1;
              r_row     <= '0;
              r_col     <= '0;
              r_idx     <= '0;
            end
          end
        end
        S_SCAN: begin
          r_nxt[r_idx] <= w_new_cell;
          r_idx        <= r_idx + 1'b1;
          if (r_col == LAST_C) begin
            r_col <= '0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
          if (r_idx == LAST_IDX) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_cur   <= r_nxt;
          r_gen   <= r_gen + 16'd1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_prow
    for (genvar gc = 0; gc < COLS; gc++) begin : g_pcol
      localparam int K = gr * COLS + gc;
      logic w_here;
      assign w_here = w_cursor_ok && (edit_row == 4'(gr)) && (edit_col == 4'(gc));
      assign w_pix[2*K +: 2] = w_here ? (r_cur[K] ? 2'b10 : 2'b01) : {2{r_cur[K]}};
      assign pixiv[gr][gc]   = r_pix[2*K +: 2];
    end
  end

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) r_pix <= '0;
    else           r_pix <= w_pix;
  end

  assign busy       = r_busy;
  assign generation = r_gen;

endmodule

// File: tb/tb_life_grid_engine.sv
// Randomized scoreboard bench for life_grid_engine: toroidal and bounded instances side by side.
module tb_life_grid_engine;
  localparam int R = 12;
  localparam int C = 12;
  localparam int TD = 10;
  localparam int NC = R * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, step, we, ev, sc;
  logic [3:0] er, ec;
  logic [1:0] pix1 [R][C];
  logic [1:0] pix0 [R][C];
  logic busy1, busy0;
  logic [15:0] gen1, gen0;

  life_grid_engine #(.ROWS(R), .COLS(C), .TICK_DIV(TD), .WRAP(1)) dut1 (
    .clk_in(clk), .reset_btn(rst), .run(run), .step(step), .edit_we(we),
    .edit_row(er), .edit_col(ec), .edit_val(ev), .show_cursor(sc),
    .pixiv(pix1), .busy(busy1), .generation(gen1));

  life_grid_engine #(.ROWS(R), .COLS(C), .TICK_DIV(TD), .WRAP(0)) dut0 (
    .clk_in(clk), .reset_btn(rst), .run(run), .step(step), .edit_we(we),
    .edit_row(er), .edit_col(ec), .edit_val(ev), .show_cursor(sc),
    .pixiv(pix0), .busy(busy0), .generation(gen0));

  typedef logic [NC-1:0] grid_t;
  typedef struct packed { grid_t g1; grid_t g0; logic [15:0] gen; } exp_t;

  exp_t sb[$];
  int commit_cyc[$];
  grid_t m1, m0;
  logic [15:0] exp_gen;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic grid_t life_next(grid_t g, bit wrap);
    grid_t n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < R && cc >= 0 && cc < C)
              cnt += int'(g[rr*C+cc]);
          end
        end
        n[r*C+c] = (cnt == 3) || (g[r*C+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] exp_pix(grid_t g, int r, int c);
    logic a;
    a = g[r*C+c];
    if (sc && int'(er) < R && int'(ec) < C && int'(er) == r && int'(ec) == c)
      return a ? 2'b10 : 2'b01;
    return a ? 2'b11 : 2'b00;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_pix(input string name, input grid_t g1, input grid_t g0);
    int bad1, bad0, r1, c1, r0, c0;
    bad1 = 0; bad0 = 0; r1 = 0; c1 = 0; r0 = 0; c0 = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (pix1[r][c] !== exp_pix(g1, r, c)) begin
          if (bad1 == 0) begin r1 = r; c1 = c; end
          bad1++;
        end
        if (pix0[r][c] !== exp_pix(g0, r, c)) begin
          if (bad0 == 0) begin r0 = r; c0 = c; end
          bad0++;
        end
      end
    end
    checks += 2;
    if (bad1 != 0) begin
      errors++;
      $display("FAIL %s wrap1: %0d cells differ, first (%0d,%0d) got %b want %b",
               name, bad1, r1, c1, pix1[r1][c1], exp_pix(g1, r1, c1));
    end
    if (bad0 != 0) begin
      errors++;
      $display("FAIL %s wrap0: %0d cells differ, first (%0d,%0d) got %b want %b",
               name, bad0, r0, c0, pix0[r0][c0], exp_pix(g0, r0, c0));
    end
  endtask

  // Monitor: a busy falling edge marks a commit; pixiv is compared one cycle later.
  initial begin : monitor
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pb = 1'b0;
      end else begin
        if (pb && !busy1) begin
          commit_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got generation %0d want no commit", gen1);
          end else begin
            e = sb.pop_front();
            check_val("commit_gen_wrap1", 32'(gen1), 32'(e.gen));
            check_val("commit_gen_wrap0", 32'(gen0), 32'(e.gen));
            @(negedge clk); #1;
            check_pix("commit_grid", e.g1, e.g0);
          end
        end
        pb = busy1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0; we = 1'b0; sc = 1'b0;
    er = '0; ec = '0; ev = 1'b0;
    m1 = '0; m0 = '0; exp_gen = '0;
    sb.delete();
    commit_cyc.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_edit(input int r, input int c, input bit v);
    if (r < R && c < C) begin
      m1[r*C+c] = v;
      m0[r*C+c] = v;
    end
  endtask

  task automatic do_edit(input int r, input int c, input bit v);
    @(negedge clk);
    we = 1'b1; er = 4'(r); ec = 4'(c); ev = v;
    model_edit(r, c, v);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic push_gen();
    exp_t e;
    exp_gen = exp_gen + 16'd1;
    m1 = life_next(m1, 1'b1);
    m0 = life_next(m0, 1'b0);
    e.g1 = m1; e.g0 = m0; e.gen = exp_gen;
    sb.push_back(e);
  endtask

  task automatic do_step(input bit with_edit, input int r, input int c, input bit v, input bit disturb);
    int d, w, want_d;
    d = 0; w = 0;
    want_d = (with_edit && r < R && c < C) ? 2 : 1;
    @(negedge clk);
    step = 1'b1;
    if (with_edit) begin
      we = 1'b1; er = 4'(r); ec = 4'(c); ev = v;
      model_edit(r, c, v);
    end
    push_gen();
    do begin
      @(negedge clk);
      step = 1'b0; we = 1'b0;
      d++;
    end while (!busy1 && d < 20);
    check_val("busy_rise_delay", 32'(d), 32'(want_d));
    if (!busy1) return;
    while (busy1 && w < 400) begin
      w++;
      if (disturb && w == 50) begin
        we = 1'b1; step = 1'b1; ev = 1'b1;
        er = 4'($urandom_range(0, R - 1));
        ec = 4'($urandom_range(0, C - 1));
      end else if (disturb && w == 51) begin
        we = 1'b0; step = 1'b0;
      end
      @(negedge clk);
    end
    check_val("busy_width", 32'(w), 32'(R * C + 1));
    tick(2);
  endtask

  initial begin : stim
    int seen, n;
    rst = 1'b1; run = 1'b0; step = 1'b0; we = 1'b0; sc = 1'b0;
    er = '0; ec = '0; ev = 1'b0;
    m1 = '0; m0 = '0; exp_gen = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);

    check_pix("reset_grid", '0, '0);
    check_val("reset_gen", 32'(gen1), 0);
    check_val("reset_busy", 32'(busy1), 0);
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy1 || busy0) seen++;
    end
    check_val("idle_busy_cycles", 32'(seen), 0);
    check_val("idle_gen", 32'(gen1), 0);

    // Blinker oscillation
    do_edit(5, 4, 1); do_edit(5, 5, 1); do_edit(5, 6, 1);
    tick(2);
    check_pix("blinker_loaded", m1, m0);
    do_step(0, 0, 0, 0, 0);
    check_val("blinker_v_top", 32'(pix1[4][5]), 3);
    check_val("blinker_v_bot", 32'(pix1[6][5]), 3);
    check_val("blinker_v_left", 32'(pix1[5][4]), 0);
    check_val("blinker_gen1", 32'(gen1), 1);
    do_step(0, 0, 0, 0, 0);
    check_val("blinker_h_left", 32'(pix1[5][4]), 3);
    check_val("blinker_h_top", 32'(pix1[4][5]), 0);
    check_val("blinker_gen2", 32'(gen1), 2);

    // Edge handling
    do_reset();
    do_edit(0, 11, 1); do_edit(0, 0, 1); do_edit(0, 1, 1);
    do_step(0, 0, 0, 0, 0);
    check_val("wrap_11_0", 32'(pix1[11][0]), 3);
    check_val("wrap_1_0", 32'(pix1[1][0]), 3);
    check_val("wrap_0_11", 32'(pix1[0][11]), 0);
    do_reset();
    do_edit(0, 4, 1); do_edit(0, 5, 1); do_edit(0, 6, 1);
    do_step(0, 0, 0, 0, 0);
    check_val("bounded_0_5", 32'(pix0[0][5]), 3);
    check_val("bounded_1_5", 32'(pix0[1][5]), 3);
    check_val("bounded_11_5", 32'(pix0[11][5]), 0);
    check_val("torus_11_5", 32'(pix1[11][5]), 3);

    // Edit with step, disturbed scan, cursor
    do_step(1, 7, 7, 1, 0);
    do_step(1, 12, 3, 1, 0);
    do_step(0, 0, 0, 0, 1);
    do_edit(3, 3, 0);
    sc = 1'b1;
    tick(2);
    check_val("cursor_dead", 32'(pix1[3][3]), 1);
    check_pix("cursor_dead_grid", m1, m0);
    do_edit(3, 3, 1);
    tick(2);
    check_val("cursor_alive", 32'(pix1[3][3]), 2);
    @(negedge clk);
    er = 4'd13;
    tick(2);
    check_val("cursor_out_of_range", 32'(pix1[3][3]), 3);
    check_pix("cursor_oor_grid", m1, m0);
    sc = 1'b0;

    // Randomized soup
    do_reset();
    repeat (40) do_edit($urandom_range(0, 13), $urandom_range(0, 13), bit'($urandom_range(0, 1)));
    tick(2);
    check_pix("random_loaded", m1, m0);
    repeat (6)
      do_step(bit'($urandom_range(0, 1)), $urandom_range(0, 13), $urandom_range(0, 13),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

    // Reset in the middle of a scan
    do_edit(2, 2, 1); do_edit(2, 3, 1); do_edit(2, 4, 1);
    tick(2);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (69) @(negedge clk);
    rst = 1'b1;
    #1;
    m1 = '0; m0 = '0; exp_gen = '0;
    check_val("midscan_rst_busy", 32'(busy1), 0);
    check_val("midscan_rst_gen", 32'(gen1), 0);
    check_pix("midscan_rst_grid", '0, '0);
    @(negedge clk);
    rst = 1'b0;
    commit_cyc.delete();
    tick(300);
    check_val("after_rst_gen", 32'(gen1), 0);
    check_pix("after_rst_grid", '0, '0);

    // Periodic generations
    do_reset();
    do_edit(5, 4, 1); do_edit(5, 5, 1); do_edit(5, 6, 1);
    tick(2);
    repeat (3) push_gen();
    @(negedge clk);
    run = 1'b1;
    n = 0;
    while (gen1 != 16'd3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("run_gen3", 32'(gen1), 3);
    tick(3);
    run = 1'b0;
    tick(300);
    check_val("run_held_gen", 32'(gen1), 3);
    check_val("run_commits", 32'(commit_cyc.size()), 3);
    if (commit_cyc.size() >= 3) begin
      check_val("run_period_a", 32'(commit_cyc[1] - commit_cyc[0]), 32'(TD + R * C + 1));
      check_val("run_period_b", 32'(commit_cyc[2] - commit_cyc[1]), 32'(TD + R * C + 1));
    end
    push_gen();
    @(negedge clk);
    run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy1 && n < 50);
    run = 1'b0;
    check_val("resume_tick_delay", 32'(n), 32'(TD - 3));
    n = 0;
    while (busy1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tick(300);
    check_val("final_gen", 32'(gen1), 4);
    check_val("scoreboard_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
